// File: rtl/rf_pkg.sv
// Shared register-file types and constants, used by the register file and its
// writeback arbiter.
package rf_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_NREGS = 32;
    localparam logic [RF_AW-1:0] RF_ZERO_ADDR = '0;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter. It scans from ptr upward, wrapping modulo N.
// It is purely combinational so that the read-port sharing block can reuse it.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [IW:0] NW = (IW+1)'(N);

    logic [IW:0]   sum;
    logic [IW-1:0] sel;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = '0;
        sel = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= NW) sum = sum - NW;
            sel = sum[IW-1:0];
            if (en && !any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port among NREQ writeback
// sources. The winning write is registered. RFARB_COLLISION_CHK_EN adds a
// sticky flag for same-address requests.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter  int NREQ = 3,
    parameter  int AW   = RF_AW,
    parameter  int DW   = RF_DW,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [NREQ-1:0]    ReqValid,
    input  logic [NREQ*AW-1:0] ReqAddr,
    input  logic [NREQ*DW-1:0] ReqData,
    output logic [NREQ-1:0]    ReqReady,
    input  logic               Hold,
    output logic               RegWrite,
    output logic [AW-1:0]      WriteAddr,
    output logic [DW-1:0]      WriteData,
    output logic [IW-1:0]      GrantId,
    output logic               Collision
);

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            gany;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            reg_write_q, reg_write_d;
    logic [AW-1:0]   write_addr_q, write_addr_d;
    logic [DW-1:0]   write_data_q, write_data_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req (ReqValid),
        .ptr (ptr_q),
        .en  (~Hold),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    // Requesters must not see an acceptance while the output stage is held in reset.
    assign ReqReady = Reset_n ? gnt : '0;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | ReqAddr[i*AW +: AW];
                sel_data = sel_data | ReqData[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        if (gany) begin
            ptr_d        = (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
            // Writes to register 0 are accepted here but never reach the file.
            reg_write_d  = (sel_addr != '0);
            write_addr_d = sel_addr;
            write_data_d = sel_data;
            grant_id_d   = gidx;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q        <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign WriteAddr = write_addr_q;
    assign WriteData = write_data_q;
    assign GrantId   = grant_id_q;

`ifdef RFARB_COLLISION_CHK_EN
    logic collision_q, collision_d, dup;

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (ReqValid[i] && ReqValid[j] &&
                    ReqAddr[i*AW +: AW] == ReqAddr[j*AW +: AW] &&
                    ReqAddr[i*AW +: AW] != '0)
                    dup = 1'b1;
            end
        end
        collision_d = collision_q | dup;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) collision_q <= 1'b0;
        else          collision_q <= collision_d;
    end

    assign Collision = collision_q;
`else
    assign Collision = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases with literal expectations, then
// random traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic [N-1:0]      ReqValid = '0;
    logic [N*AW-1:0]   ReqAddr = '0;
    logic [N*DW-1:0]   ReqData = '0;
    logic [N-1:0]      ReqReady;
    logic              Hold = 1'b0;
    logic              RegWrite;
    logic [AW-1:0]     WriteAddr;
    logic [DW-1:0]     WriteData;
    logic [IW-1:0]     GrantId;
    logic              Collision;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int            m_ptr;
    bit            m_rw;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_gid;
    bit            m_col;
    logic [N-1:0]  m_xfer;

    regfile_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .ReqValid  (ReqValid),
        .ReqAddr   (ReqAddr),
        .ReqData   (ReqData),
        .ReqReady  (ReqReady),
        .Hold      (Hold),
        .RegWrite  (RegWrite),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .GrantId   (GrantId),
        .Collision (Collision)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // The winner is the valid requester at the smallest rotational distance from ptr.
    function automatic int exp_grant();
        int best = -1, bestd = N;
        for (int i = 0; i < N; i++) begin
            if (ReqValid[i]) begin
                int d = (i - m_ptr + N) % N;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    function automatic bit dup_present();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j && ReqValid[i] && ReqValid[j] &&
                    ReqAddr[i*AW +: AW] == ReqAddr[j*AW +: AW] && ReqAddr[i*AW +: AW] != 0)
                    return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_rw = 0; m_wa = '0; m_wd = '0; m_gid = 0; m_col = 0; m_xfer = '0;
    endtask

    task automatic model_next();
        int g;
        m_xfer = '0;
        if (!Reset_n) begin
            model_reset();
        end else begin
            g = exp_grant();
            if (!Hold && g >= 0) begin
                m_wa  = ReqAddr[g*AW +: AW];
                m_wd  = ReqData[g*DW +: DW];
                m_rw  = (m_wa != 0);
                m_gid = g;
                m_ptr = (g + 1) % N;
                m_xfer[g] = 1'b1;
            end else begin
                m_rw = 0;
            end
            if (dup_present()) m_col = 1;
        end
    endtask

    task automatic check_all();
        int g;
        logic [N-1:0] rdy;
        g = exp_grant();
        rdy = '0;
        if (Reset_n && !Hold && g >= 0) rdy[g] = 1'b1;
        chk("model ReqReady", ReqReady, rdy);
        chk("model RegWrite", RegWrite, m_rw);
        chk("model WriteAddr", WriteAddr, m_wa);
        chk("model WriteData", WriteData, m_wd);
        chk("model GrantId", GrantId, m_gid);
`ifdef RFARB_COLLISION_CHK_EN
        chk("model Collision", Collision, m_col);
`else
        chk("model Collision", Collision, 0);
`endif
    endtask

    task automatic settle();
        @(negedge Clock);
        check_all();
    endtask

    task automatic advance();
        model_next();
        @(posedge Clock);
        #1;
    endtask

    // Reset is asserted asynchronously mid-cycle; outputs must clear at once.
    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst RegWrite", RegWrite, 0);
        chk("rst WriteAddr", WriteAddr, 0);
        chk("rst ReqReady", ReqReady, 0);
        check_all();
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ReqValid[i] = v;
        ReqAddr[i*AW +: AW] = a;
        ReqData[i*DW +: DW] = d;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        settle();
        chk("reset RegWrite", RegWrite, 0);
        chk("reset WriteAddr", WriteAddr, 0);
        chk("reset GrantId", GrantId, 0);
        chk("reset ReqReady", ReqReady, 0);

        // single requester
        advance();
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        settle();
        chk("single ReqReady", ReqReady, 3'b010);
        advance();
        ReqValid = '0;
        settle();
        chk("single RegWrite", RegWrite, 1);
        chk("single WriteAddr", WriteAddr, 7);
        chk("single WriteData", WriteData, 32'hDEADBEEF);
        chk("single GrantId", GrantId, 1);

        // reset mid-stream, then round-robin across all three
        advance();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 32'h100 + DW'(i));
        settle();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr ReqReady", ReqReady, 64'(1) << (k % 3));
            if (k > 0) begin
                chk("rr GrantId", GrantId, (k - 1) % 3);
                chk("rr RegWrite", RegWrite, 1);
            end
            advance();
        end
        ReqValid = '0;
        settle();
        chk("rr last GrantId", GrantId, 2);
        chk("rr last RegWrite", RegWrite, 1);

        // address-0 write is accepted but dropped
        advance();
        set_req(2, 1'b1, 5'd0, 32'h1234);
        settle();
        chk("zero ReqReady", ReqReady, 3'b100);
        advance();
        ReqValid = '0;
        settle();
        chk("zero RegWrite", RegWrite, 0);
        chk("zero WriteData", WriteData, 32'h1234);
        chk("zero GrantId", GrantId, 2);

        // hold
        advance();
        set_req(0, 1'b1, 5'd4, 32'hA5A5A5A5);
        settle();
        chk("hold pre ReqReady", ReqReady, 3'b001);
        advance();
        set_req(0, 1'b1, 5'd6, 32'h5A5A5A5A);
        Hold = 1'b1;
        settle();
        chk("hold ReqReady", ReqReady, 0);
        chk("hold inflight RegWrite", RegWrite, 1);
        chk("hold inflight WriteAddr", WriteAddr, 4);
        for (int k = 0; k < 2; k++) begin
            advance();
            settle();
            chk("hold ReqReady", ReqReady, 0);
            chk("hold RegWrite", RegWrite, 0);
        end
        advance();
        Hold = 1'b0;
        settle();
        chk("unhold ReqReady", ReqReady, 3'b001);
        advance();
        ReqValid = '0;
        settle();
        chk("unhold RegWrite", RegWrite, 1);
        chk("unhold WriteAddr", WriteAddr, 6);
        chk("unhold WriteData", WriteData, 32'h5A5A5A5A);

`ifdef RFARB_COLLISION_CHK_EN
        do_reset();
        set_req(0, 1'b1, 5'd9, 32'h1);
        set_req(1, 1'b1, 5'd9, 32'h2);
        settle();
        chk("col ReqReady0", ReqReady, 3'b001);
        chk("col before", Collision, 0);
        advance();
        ReqValid[0] = 1'b0;
        settle();
        chk("col set", Collision, 1);
        chk("col first GrantId", GrantId, 0);
        chk("col ReqReady1", ReqReady, 3'b010);
        advance();
        ReqValid = '0;
        settle();
        chk("col second GrantId", GrantId, 1);
        chk("col second WriteData", WriteData, 32'h2);
        advance();
        settle();
        chk("col sticky", Collision, 1);
`endif

        // random traffic against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else advance();
            for (int i = 0; i < N; i++) begin
                if (m_xfer[i] || !ReqValid[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1'b1, AW'($urandom_range(0, 7)), DW'($urandom));
                    else
                        ReqValid[i] = 1'b0;
                end
            end
            Hold = ($urandom_range(0, 4) == 0);
            settle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (RegWrite/WriteAddr/WriteData) among NREQ writeback requesters, e.g. ALU, load unit and mul/div. Uses round-robin arbitration with a per-requester valid/ready handshake. The winning write is registered, so the register file sees a clean one-write-per-cycle stream one cycle after acceptance. Sits between the execute/memory writeback sources and the register file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
AW, 5, register address width
DW, 32, register data width

Ports:
Clock  input  1  system clock, all state on rising edge
Reset_n  input  1  one clock; reset is asynchronous and active-low
ReqValid  input  NREQ  requester i has a write pending
ReqAddr  input  NREQ*AW  requester i destination, slice [i*AW +: AW]
ReqData  input  NREQ*DW  requester i data, slice [i*DW +: DW]
ReqReady  output  NREQ  one-hot (or zero) acceptance, combinational
Hold  input  1  pipeline freeze, no grants while high
RegWrite  output  1  to register file write enable, registered
WriteAddr  output  AW  to register file, registered
WriteData  output  DW  to register file, registered
GrantId  output  clog2(NREQ)  index of the requester behind the current RegWrite, registered
Collision  output  1  sticky error flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (Reset_n low, asynchronous): RegWrite=0, WriteAddr=0, WriteData=0, GrantId=0, rr pointer=0, Collision=0. An in-flight registered write is discarded. ReqReady is 0 while Reset_n is low.
- Arbitration (combinational): if Hold=0, the grant goes to the first i with ReqValid[i]=1, scanning ptr, ptr+1, … mod NREQ. ReqReady[grant]=1; all other ReqReady=0. With no valid requester or Hold=1, ReqReady=0.
- A transfer occurs when ReqValid[i] and ReqReady[i] are both high on a rising edge. A requester must hold Valid/Addr/Data stable until its transfer.
- Pointer update: on a transfer, ptr <= (grant+1) mod NREQ. Otherwise ptr holds.
- Output stage, latency 1 cycle: on a transfer, the next cycle has WriteAddr=ReqAddr[g], WriteData=ReqData[g], GrantId=g, and RegWrite=1 only if the address is nonzero.
  - Address-0 writes are accepted (ReqReady asserted) but dropped: RegWrite=0, with WriteAddr/WriteData still updated.
- No transfer in a cycle: RegWrite=0 next cycle; WriteAddr/WriteData/GrantId hold their last values.
- Throughput: one write per cycle sustained. Back-to-back grants to different requesters are allowed.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0… Worst-case wait is NREQ-1 cycles.
- Hold: asserting Hold blocks new grants the same cycle. A write already registered still completes on the following edge. Deasserting Hold resumes from the unchanged ptr.
- Reset mid-operation: pending requester data is not lost; the requester retries after reset because ReqValid persists. Only the registered stage is cleared.
- Same-address requests from two requesters in one cycle are serialized in round-robin order. The later grant wins in the register file.

Optional Feature:
Macro RFARB_COLLISION_CHK_EN.
- Defined: each cycle, if two or more requesters are valid with the same nonzero ReqAddr, Collision is set to 1. Collision is sticky and cleared only by reset. Arbitration is unaffected.
- Undefined: no comparator logic is built; Collision is tied to 0.

Decomposition:
- Shared package rf_pkg holds:
  - constants RF_AW=5, RF_DW=32, RF_NREGS=32, RF_ZERO_ADDR=0
  - typedefs rf_addr_t and rf_data_t, reused by the register file and this block
- One natural sub-module: rr_arbiter (NREQ-wide round-robin, inputs req/ptr/en, outputs one-hot grant and index). It is reusable for the future read-port sharing block.

Test Plan:
- Reset: Reset_n low mid-stream with ReqValid=3'b111 -> RegWrite=0, WriteAddr=0, ReqReady=0 immediately. First post-reset grant goes to requester 0.
- Single requester: ReqValid=3'b010, addr=5'd7, data=32'hDEADBEEF -> ReqReady=3'b010 in the same cycle. Next cycle RegWrite=1, WriteAddr=7, WriteData=DEADBEEF, GrantId=1.
- Round-robin: all three valid for 6 cycles with addrs 1/2/3 -> GrantId sequence 0,1,2,0,1,2 and RegWrite=1 every cycle from cycle 2.
- Zero address: requester 2 with addr 0, data 32'h1234 -> ReqReady[2]=1; next cycle RegWrite=0, WriteData=32'h1234.
- Hold: Hold=1 for 3 cycles with requester 0 valid -> ReqReady=0 and RegWrite=0 after the in-flight write. Hold=0 -> grant to 0 the same cycle.
- Collision (RFARB_COLLISION_CHK_EN): requesters 0 and 1 both valid with addr 9 -> Collision=1 next cycle and stays 1 until Reset_n; writes are issued in order 0 then 1.
